// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter feeding one registered ready/valid output port
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [IDW-1:0]         grant_id_o
);

  localparam int SW = IDW + 1;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IDW-1:0]   out_id;
  logic [IDW-1:0]   rr_ptr;

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;
  logic [SW-1:0]      offset;
  logic [SW-1:0]      sum;
  logic [IDW-1:0]     winner;
  logic [WIDTH-1:0]   win_data;
  logic               any_valid;
  logic               load_en;
  logic               accept;

  assign any_valid = |req_valid_i;
  // Reset gating keeps req_ready_o quiet while rst_n is low.
  assign load_en   = rst_n && !flush_i && (!out_valid || ready_in);
  assign accept    = load_en && any_valid;

  // Rotate the valids so bit 0 is rr_ptr; the lowest set bit is the winner's distance.
  always_comb begin
    dbl     = {req_valid_i, req_valid_i};
    shifted = dbl >> rr_ptr;
    rot     = shifted[N_REQ-1:0];
    offset  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = SW'(k);
    end
    sum = {1'b0, rr_ptr} + offset;
    if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
    winner = sum[IDW-1:0];
  end

  always_comb begin
    win_data    = '0;
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDW'(i)) begin
        win_data       = req_data_i[i*WIDTH +: WIDTH];
        req_ready_o[i] = accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_id    <= winner;
      rr_ptr    <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (out_valid && ready_in) begin
      out_valid <= 1'b0;
    end
  end

  assign valid_out  = out_valid;
  assign data_out   = out_data;
  assign grant_id_o = out_id;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter (N_REQ=4 and N_REQ=3)
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  v4;
  logic [3:0]  rdy4;
  logic [31:0] d4;
  logic        vo4;
  logic        ri4;
  logic [7:0]  do4;
  logic [1:0]  id4;

  logic [2:0]  v3;
  logic [2:0]  rdy3;
  logic [23:0] d3;
  logic        vo3;
  logic [7:0]  do3;
  logic [1:0]  id3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(v4), .req_ready_o(rdy4), .req_data_i(d4),
    .valid_out(vo4), .ready_in(ri4), .data_out(do4), .grant_id_o(id4)
  );

  cdb_arbiter #(.N_REQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_data_i(d3),
    .valid_out(vo3), .ready_in(1'b1), .data_out(do3), .grant_id_o(id3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    chk({tag, ".valid"}, 32'(vo4), 32'(v));
    chk({tag, ".data"}, 32'(do4), 32'(d));
    chk({tag, ".id"}, 32'(id4), 32'(id));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ri4   = 1'b1;
    v4    = 4'b1111;
    v3    = 3'b000;
    for (int i = 0; i < 4; i++) d4[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 3; i++) d3[i*8 +: 8] = 8'hB0 + 8'(i);

    step();
    step();
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.ready", 32'(rdy4), 32'h0);

    rst_n = 1'b1;
    #1;
    chk("first.ready", 32'(rdy4), 32'b0001);

    for (int c = 0; c < 8; c++) begin
      step();
      chk_out($sformatf("sweep%0d", c), 1'b1, 8'hA0 + 8'(c % 4), 2'(c % 4));
      chk($sformatf("sweep%0d.ready", c), 32'(rdy4), 32'(1) << ((c + 1) % 4));
    end

    v4 = 4'b0010;
    step();
    chk_out("to_ptr2", 1'b1, 8'hA1, 2'd1);
    v4 = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("sparse%0d.id", c), 32'(id4), (c % 2 == 0) ? 32'd3 : 32'd1);
    end

    d4[2*8 +: 8] = 8'h55;
    v4 = 4'b0100;
    step();
    chk_out("bp_accept", 1'b1, 8'h55, 2'd2);
    ri4 = 1'b0;
    v4  = 4'b1111;
    #1;
    chk("bp_ready_now", 32'(rdy4), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out($sformatf("bp_hold%0d", c), 1'b1, 8'h55, 2'd2);
      chk($sformatf("bp_hold%0d.ready", c), 32'(rdy4), 32'h0);
    end
    ri4 = 1'b1;
    #1;
    chk("bp_release.ready", 32'(rdy4), 32'b1000);
    step();
    chk_out("bp_refill", 1'b1, 8'hA3, 2'd3);

    ri4 = 1'b0;
    step();
    chk_out("stall", 1'b1, 8'hA3, 2'd3);
    flush = 1'b1;
    ri4   = 1'b1;
    v4    = 4'b0010;
    #1;
    chk("flush.ready", 32'(rdy4), 32'h0);
    step();
    chk_out("flushed", 1'b0, 8'h00, 2'd0);
    flush = 1'b0;
    v4    = 4'b0011;
    #1;
    chk("post_flush.ptr_kept", 32'(rdy4), 32'b0001);
    v4 = 4'b0010;
    #1;
    chk("post_flush.ready", 32'(rdy4), 32'b0010);
    step();
    chk_out("post_flush", 1'b1, 8'hA1, 2'd1);
    v4 = 4'b0000;
    step();
    chk_out("drain", 1'b0, 8'hA1, 2'd1);

    v4 = 4'b1111;
    step();
    rst_n = 1'b0;
    v3    = 3'b111;
    #1;
    chk("rst_mid.ready", 32'(rdy4), 32'h0);
    step();
    chk_out("rst_mid", 1'b0, 8'h00, 2'd0);
    chk("n3.reset.valid", 32'(vo3), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("n3_%0d.id", c), 32'(id3), 32'(c % 3));
      chk($sformatf("n3_%0d.data", c), 32'(do3), 32'(8'hB0 + 8'(c % 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares one registered ready/valid output port, such as the common data bus or writeback port, among `N_REQ` producers such as functional units. Each cycle it picks at most one valid requester, fairly, and captures its payload and source index into a single output register. The block sustains one transfer per cycle while `ready_in` is high. `flush_i` discards the buffered entry during pipeline recovery.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 1..16.
- `WIDTH`, default 32: payload width per requester.
- `IDW` (localparam): `N_REQ>1 ? $clog2(N_REQ) : 1`.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  synchronous flush; drops the output entry and blocks acceptance this cycle.
- `req_valid_i`  in  `N_REQ`  per-requester valid.
- `req_ready_o`  out  `N_REQ`  per-requester ready; one-hot or zero.
- `req_data_i`  in  `N_REQ*WIDTH`  packed payloads; requester i occupies `[i*WIDTH +: WIDTH]`.
- `valid_out`  out  1  output entry valid.
- `ready_in`  in  1  downstream ready.
- `data_out`  out  `WIDTH`  payload of the output entry.
- `grant_id_o`  out  `IDW`  index of the requester that produced the entry.

## Operation
- State:
  - `out_valid`, `out_data`, `out_id`: the single output entry.
  - `rr_ptr[IDW]`: the highest-priority requester index.
- Load enable:
  - `load_en = !flush_i && (!out_valid || ready_in)`.
  - A full entry that is drained in the same cycle can be refilled in that cycle.
- Winner selection:
  - The winner is the first index with `req_valid_i` set, scanning cyclically from `rr_ptr` upward: `rr_ptr`, `rr_ptr+1`, …, wrapping `N_REQ-1` to 0.
  - Indices are computed mod `N_REQ`. There is no power-of-2 assumption.
- Ready output:
  - `req_ready_o[winner] = load_en && any_valid`.
  - All other bits are 0.
  - `req_ready_o` depends combinationally on `req_valid_i`. Requesters must not make valid depend on ready.
- Accept (`load_en && any_valid`):
  - `out_valid<=1`, `out_data<=req_data_i[winner]`, `out_id<=winner`.
  - `rr_ptr <= (winner==N_REQ-1) ? 0 : winner+1`.
- Drain without refill (`out_valid && ready_in && !any_valid && !flush_i`): `out_valid<=0`. `out_data` and `out_id` hold their values.
- Stall (`out_valid && !ready_in`):
  - The entry holds.
  - `valid_out`, `data_out` and `grant_id_o` stay stable until the handshake.
- Flush (`flush_i=1`, takes priority over accept and drain):
  - `out_valid<=0`, `out_data<='0`, `out_id<='0`.
  - `req_ready_o` is all 0, so no requester is consumed.
  - `rr_ptr` is unchanged.
  - `valid_out` is still driven from the current entry during the flush cycle. Downstream ignores it under flush.
- Fairness: a requester held continuously valid is accepted within `N_REQ` accepts.
- `N_REQ=1`: `rr_ptr` is constantly 0. The block behaves as a 1-entry pipeline register.

## Timing
- Reset (`rst_n=0` at the edge), regardless of any pending handshake:
  - `out_valid=0`, `out_data=0`, `out_id=0`, `rr_ptr=0`.
  - Therefore `valid_out=0`, `data_out=0`, `grant_id_o=0`.
  - `req_ready_o` is all 0 while `rst_n=0`.
- Latency: a requester accepted at edge k appears on `valid_out` at k+1. The output is fully registered.
- Throughput: with `ready_in=1` constantly, one accept per cycle with no bubbles.
- Backpressure: the cycle after `ready_in` falls with an entry held, every `req_ready_o` is 0.
- Simultaneous flush and `ready_in`: flush wins. The entry is dropped, not counted as transferred, and no new accept occurs.
- Reset or flush mid-stall: the held entry is lost. After flush there is no requester-side replay; upstream owns recovery.
- Outputs change only at clock edges, except `req_ready_o`, which is combinational.

## Test plan
- Reset then idle:
  - Hold `rst_n=0` for 2 cycles with all requests valid → `valid_out=0`, `req_ready_o=0000`.
  - After release, the first accept is requester 0 (`grant_id_o=0` next cycle).
- Round-robin sweep: `N_REQ=4`, all four valid, `ready_in=1` for 8 cycles, payload = `0xA0+i` → `grant_id_o` sequence 0,1,2,3,0,1,2,3, `data_out` matches, no bubbles.
- Sparse wrap: only requesters 1 and 3 valid, `rr_ptr=2` → order 3,1,3,1. `rr_ptr` wraps from 3 to 0, then selects 1.
- Backpressure:
  - Accept requester 2 with data `0x55`, then drop `ready_in` for 3 cycles → `valid_out=1`, `data_out=0x55`, `grant_id_o=2` stable, `req_ready_o=0000`.
  - Raise `ready_in` → same-cycle refill from the next requester.
- Flush:
  - Entry valid and stalled; assert `flush_i` with `ready_in=1` and requester 1 valid → next cycle `valid_out=0`, `req_ready_o` was 0000 in the flush cycle, `rr_ptr` unchanged.
  - The following cycle, requester 1 is accepted.
- Non-power-of-2: `N_REQ=3`, all valid, 6 accepts → ids 0,1,2,0,1,2. `rr_ptr` never reaches 3.
